// File: rtl/tdm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tdm_pkg                                                       |
// | Purpose  : Shared definitions for the TDM demultiplexer: framer state    |
// |            encoding, default sample width / slot count, and the width    |
// |            of the slot index.                                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package tdm_pkg;

  // Framer states. The encoding is fixed: HUNT=0, LOCKED=1.
  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_e;

  localparam int TDM_DEFAULT_WIDTH = 8;
  localparam int TDM_DEFAULT_NCH   = 4;

  // Bits needed to index NCH slots, ceil(log2(NCH)), never less than one.
  function automatic int tdm_slot_w(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tdm_slot_counter                                              |
// | Purpose  : Slot index for the TDM framer. Wraps NCH-1 -> 0 on increment, |
// |            can be loaded to 1 (slot 0 just consumed) or cleared.         |
// | Ports    : clk, rst  - clock, synchronous active-high reset              |
// |            i_clr     - force slot to 0                                   |
// |            i_load1   - force slot to 1                                   |
// |            i_inc     - advance slot with wrap                            |
// |            o_slot    - current slot index                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NCH = TDM_DEFAULT_NCH,
  parameter int SW  = tdm_slot_w(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load1,
  input  logic          i_inc,
  output logic [SW-1:0] o_slot
);

  localparam logic [SW-1:0] c_last_slot = SW'(NCH - 1);

  logic [SW-1:0] r_slot;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_slot <= '0;
    end else if (i_load1) begin
      r_slot <= SW'(1);
    end else if (i_inc) begin
      r_slot <= (r_slot == c_last_slot) ? '0 : r_slot + SW'(1);
    end
  end

  assign o_slot = r_slot;

endmodule : tdm_slot_counter
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tdm_demux                                                     |
// | Purpose  : Splits a TDM sample stream into NCH per-slot channels and     |
// |            assembles complete frames. A two-state framer (HUNT/LOCKED)   |
// |            aligns on in_sof and flags alignment errors.                  |
// | Ports    : clk, rst    - clock, synchronous active-high reset            |
// |            in_valid    - in_data / in_sof qualifier                      |
// |            in_data     - one TDM sample                                  |
// |            in_sof      - sample is slot 0                                |
// |            ch_data     - latest sample per slot, slot k at [k*W +: W]    |
// |            ch_valid    - per-slot update pulse                           |
// |            frame_data  - last complete frame, same layout as ch_data     |
// |            frame_valid - frame_data update pulse                         |
// |            locked      - framer is in LOCKED                             |
// |            sync_err    - alignment error pulse                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_DEFAULT_WIDTH,
  parameter int NCH   = TDM_DEFAULT_NCH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sof,
  output logic [NCH*WIDTH-1:0] ch_data,
  output logic [NCH-1:0]       ch_valid,
  output logic [NCH*WIDTH-1:0] frame_data,
  output logic                 frame_valid,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int            SW          = tdm_slot_w(NCH);
  localparam logic [SW-1:0] c_last_slot = SW'(NCH - 1);

  tdm_state_e            r_state;
  tdm_state_e            w_state_next;
  logic [SW-1:0]         w_slot;
  logic [SW-1:0]         w_wr_slot;
  logic                  w_store;
  logic                  w_sync_err;
  logic                  w_cnt_clr;
  logic                  w_cnt_load1;
  logic                  w_cnt_inc;
  logic                  w_frame_done;
  logic [NCH-1:0]        w_wr_en;
  logic [NCH*WIDTH-1:0]  w_frame_next;

  logic [NCH*WIDTH-1:0]  r_ch_data;
  logic [NCH-1:0]        r_ch_valid;
  logic [NCH*WIDTH-1:0]  r_frame_data;
  logic                  r_frame_valid;
  logic                  r_sync_err;

  tdm_slot_counter #(
    .NCH (NCH),
    .SW  (SW)
  ) u_slot_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_load1 (w_cnt_load1),
    .i_inc   (w_cnt_inc),
    .o_slot  (w_slot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Framer decision for the current valid sample. An in_sof sample always
  // lands in slot 0; it is an error only if we expected a later slot.
  // A non-sof sample where slot 0 is expected means alignment was lost, so
  // the sample is dropped and the framer goes back to hunting.
  always_comb begin
    w_state_next = r_state;
    w_store      = 1'b0;
    w_wr_slot    = w_slot;
    w_sync_err   = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_load1  = 1'b0;
    w_cnt_inc    = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (in_sof) begin
            w_store      = 1'b1;
            w_wr_slot    = '0;
            w_cnt_load1  = 1'b1;
            w_state_next = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (in_sof) begin
            w_store     = 1'b1;
            w_wr_slot   = '0;
            w_cnt_load1 = 1'b1;
            w_sync_err  = (w_slot != '0);
          end else if (w_slot == '0) begin
            w_sync_err   = 1'b1;
            w_cnt_clr    = 1'b1;
            w_state_next = ST_HUNT;
          end else begin
            w_store   = 1'b1;
            w_cnt_inc = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_HUNT;
        end
      endcase
    end
  end

  // A frame completes only when the last slot is written in sequence; a
  // resync jumps back to slot 0 and never reaches this point early.
  assign w_frame_done = w_store && (w_wr_slot == c_last_slot);

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_slot
      assign w_wr_en[k] = w_store && (w_wr_slot == SW'(k));

      // Frame image includes the sample being written this cycle.
      assign w_frame_next[k*WIDTH +: WIDTH] =
        w_wr_en[k] ? in_data : r_ch_data[k*WIDTH +: WIDTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ch_data[k*WIDTH +: WIDTH] <= '0;
        end else if (w_wr_en[k]) begin
          r_ch_data[k*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_valid    <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_ch_valid    <= w_wr_en;
      r_frame_valid <= w_frame_done;
      r_sync_err    <= w_sync_err;
      if (w_frame_done) begin
        r_frame_data <= w_frame_next;
      end
    end
  end

  assign ch_data     = r_ch_data;
  assign ch_valid    = r_ch_valid;
  assign frame_data  = r_frame_data;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = (r_state == ST_LOCKED);

endmodule : tdm_demux
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tdm_demux                                                  |
// | Purpose  : Self-checking bench for tdm_demux (WIDTH=8, NCH=4): directed  |
// |            scenarios followed by randomized traffic, all outputs         |
// |            compared against a frame-position reference model.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_tdm_demux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int TW    = NCH * WIDTH;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_sof;
  logic [TW-1:0]    ch_data;
  logic [NCH-1:0]   ch_valid;
  logic [TW-1:0]    frame_data;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  tdm_demux #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sof      (in_sof),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: "aligned" flag plus the position within the frame
  // where the next sample is expected.
  bit               m_aligned;
  int               m_pos;
  logic [WIDTH-1:0] m_ch    [NCH];
  logic [WIDTH-1:0] m_frame [NCH];
  logic [NCH-1:0]   m_cv;
  logic             m_fv;
  logic             m_se;

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [TW-1:0] pack(input logic [WIDTH-1:0] a [NCH]);
    logic [TW-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*WIDTH +: WIDTH] = a[k];
    return v;
  endfunction

  task automatic model(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d);
    m_cv = '0;
    m_fv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      m_aligned = 1'b0;
      m_pos     = 0;
      for (int k = 0; k < NCH; k++) begin
        m_ch[k]    = '0;
        m_frame[k] = '0;
      end
    end else if (v) begin
      if (s) begin
        if (m_aligned && m_pos != 0) m_se = 1'b1;
        m_aligned = 1'b1;
        m_ch[0]   = d;
        m_cv[0]   = 1'b1;
        m_pos     = 1;
      end else if (m_aligned) begin
        if (m_pos == 0) begin
          m_se      = 1'b1;
          m_aligned = 1'b0;
        end else begin
          m_ch[m_pos] = d;
          m_cv[m_pos] = 1'b1;
          if (m_pos == NCH - 1) begin
            m_frame = m_ch;
            m_fv    = 1'b1;
          end
          m_pos = (m_pos + 1) % NCH;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d);
    rst      = r;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    model(r, v, s, d);
    @(posedge clk);
    #1;
    chk("ch_data",     ch_data,          pack(m_ch));
    chk("ch_valid",    TW'(ch_valid),    TW'(m_cv));
    chk("frame_data",  frame_data,       pack(m_frame));
    chk("frame_valid", TW'(frame_valid), TW'(m_fv));
    chk("locked",      TW'(locked),      TW'(m_aligned));
    chk("sync_err",    TW'(sync_err),    TW'(m_se));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
  endtask

  int gen_pos;
  bit good_sof;
  bit r_b, v_b, s_b;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      m_ch[k]    = '0;
      m_frame[k] = '0;
    end
    m_aligned = 1'b0;
    m_pos     = 0;

    // Reset state
    do_reset();
    chk("rst_ch_data", ch_data, '0);
    chk("rst_locked",  TW'(locked), '0);

    // Basic frame, back to back
    step(1'b0, 1'b1, 1'b1, 8'h11);
    chk("f1_cv0", TW'(ch_valid), TW'(4'b0001));
    step(1'b0, 1'b1, 1'b0, 8'h22);
    chk("f1_cv1", TW'(ch_valid), TW'(4'b0010));
    step(1'b0, 1'b1, 1'b0, 8'h33);
    chk("f1_cv2", TW'(ch_valid), TW'(4'b0100));
    chk("f1_fv_early", TW'(frame_valid), '0);
    step(1'b0, 1'b1, 1'b0, 8'h44);
    chk("f1_cv3",    TW'(ch_valid), TW'(4'b1000));
    chk("f1_frame",  frame_data, 32'h44332211);
    chk("f1_fv",     TW'(frame_valid), TW'(1'b1));
    chk("f1_locked", TW'(locked), TW'(1'b1));
    idle(1);
    chk("f1_fv_drop", TW'(frame_valid), '0);

    // Hunting ignores non-sof samples
    do_reset();
    step(1'b0, 1'b1, 1'b0, 8'hAA);
    chk("hunt_aa_cv", TW'(ch_valid), '0);
    step(1'b0, 1'b1, 1'b0, 8'hBB);
    chk("hunt_bb_lk", TW'(locked), '0);
    step(1'b0, 1'b1, 1'b1, 8'h01);
    chk("hunt_lock", TW'(locked), TW'(1'b1));
    chk("hunt_ch0",  TW'(ch_data[7:0]), TW'(8'h01));

    // Resync mid-frame
    do_reset();
    step(1'b0, 1'b1, 1'b1, 8'h10);
    step(1'b0, 1'b1, 1'b0, 8'h20);
    step(1'b0, 1'b1, 1'b1, 8'h30);
    chk("resync_err", TW'(sync_err), TW'(1'b1));
    chk("resync_ch0", TW'(ch_data[7:0]), TW'(8'h30));
    chk("resync_fv",  TW'(frame_valid), '0);
    step(1'b0, 1'b1, 1'b0, 8'h40);
    chk("resync_slot1", TW'(ch_valid), TW'(4'b0010));

    // Missing sof at slot 0 drops lock
    do_reset();
    step(1'b0, 1'b1, 1'b1, 8'h01);
    step(1'b0, 1'b1, 1'b0, 8'h02);
    step(1'b0, 1'b1, 1'b0, 8'h03);
    step(1'b0, 1'b1, 1'b0, 8'h04);
    step(1'b0, 1'b1, 1'b0, 8'h55);
    chk("nosof_err", TW'(sync_err), TW'(1'b1));
    chk("nosof_lk",  TW'(locked), '0);
    chk("nosof_ch",  ch_data, 32'h04030201);

    // Frame with idle gaps of 0..3 cycles
    do_reset();
    step(1'b0, 1'b1, 1'b1, 8'h11); idle(2);
    step(1'b0, 1'b1, 1'b0, 8'h22); idle(0);
    step(1'b0, 1'b1, 1'b0, 8'h33); idle(3);
    step(1'b0, 1'b1, 1'b0, 8'h44);
    chk("gap_frame", frame_data, 32'h44332211);
    chk("gap_fv",    TW'(frame_valid), TW'(1'b1));

    // Reset mid-frame, with a valid sample presented during reset
    do_reset();
    step(1'b0, 1'b1, 1'b1, 8'h11);
    step(1'b0, 1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 1'b1, 8'h99);
    chk("midrst_ch", ch_data, '0);
    chk("midrst_lk", TW'(locked), '0);
    step(1'b0, 1'b1, 1'b1, 8'hA1);
    step(1'b0, 1'b1, 1'b0, 8'hA2);
    step(1'b0, 1'b1, 1'b0, 8'hA3);
    step(1'b0, 1'b1, 1'b0, 8'hA4);
    chk("midrst_frame", frame_data, 32'hA4A3A2A1);

    // Randomized traffic: mostly well-formed framing with occasional
    // misplaced or missing sof, idle gaps and rare resets.
    gen_pos = 0;
    for (int i = 0; i < 1500; i++) begin
      r_b = ($urandom_range(0, 199) == 0);
      v_b = ($urandom_range(0, 9) < 7);
      good_sof = (gen_pos == 0);
      s_b = ($urandom_range(0, 24) == 0) ? !good_sof : good_sof;
      step(r_b, v_b, s_b, WIDTH'($urandom));
      if (r_b) gen_pos = 0;
      else if (v_b) gen_pos = s_b ? 1 : (gen_pos + 1) % NCH;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_tdm_demux
`default_nettype wire

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, the sample width in bits.
REQ-002 The block SHALL take parameter NCH, default 4, the number of TDM slots per frame; legal range 2..16.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-004 Port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port in_valid, input, 1 bit: in_data and in_sof qualified this cycle.
REQ-007 Port in_data, input, WIDTH bits: one TDM sample.
REQ-008 Port in_sof, input, 1 bit: current sample is slot 0; meaningful only with in_valid.
REQ-009 Port ch_data, output, NCH*WIDTH bits: per-slot latest sample; slot k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port ch_valid, output, NCH bits: one-cycle pulse on bit k when slot k is updated.
REQ-011 Port frame_data, output, NCH*WIDTH bits: last complete frame, same layout as ch_data.
REQ-012 Port frame_valid, output, 1 bit: one-cycle pulse when frame_data is updated.
REQ-013 Port locked, output, 1 bit: high while in LOCKED state.
REQ-014 Port sync_err, output, 1 bit: one-cycle pulse on a frame-alignment error.

Function
REQ-015 The block SHALL implement states HUNT and LOCKED, plus a slot counter of ceil(log2(NCH)) bits.
REQ-016 In HUNT, valid samples with in_sof=0 SHALL be discarded with no output pulse.
REQ-017 In HUNT, a valid sample with in_sof=1 SHALL be treated as slot 0, set slot to 1, and move to LOCKED.
REQ-018 In LOCKED, a valid sample with in_sof=0 SHALL be written to the current slot, and the slot SHALL advance by 1, wrapping from NCH-1 to 0.
REQ-019 In LOCKED, in_sof=1 with slot==0 SHALL be normal operation.
REQ-020 In LOCKED, in_sof=1 with slot!=0 SHALL pulse sync_err, store the sample as slot 0, set slot to 1, and stay LOCKED.
REQ-021 In LOCKED, a sample arriving at slot 0 with in_sof=0 SHALL pulse sync_err, be discarded, and return the block to HUNT.
REQ-022 On a stored sample, ch_data slot k and ch_valid[k] SHALL update on the edge after the in_valid cycle (latency 1).
REQ-023 Cycles with in_valid=0 SHALL change no state; ch_valid and frame_valid SHALL be 0.
REQ-024 When slot NCH-1 is stored, frame_data SHALL load all NCH slots, including the sample just received, in the same cycle that ch_valid[NCH-1] is asserted, and frame_valid SHALL pulse with it.
REQ-025 A frame truncated by resync (REQ-020) SHALL NOT update frame_data or pulse frame_valid.
REQ-026 Back-to-back in_valid SHALL be sustained at one sample per clock with no stall; there is no backpressure.

Reset
REQ-027 While rst=1, the block SHALL be in HUNT with slot=0.
REQ-028 While rst=1, ch_data, frame_data, ch_valid, frame_valid, locked and sync_err SHALL all be 0.
REQ-029 rst SHALL take priority over in_valid in the same cycle.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no frame_valid pulse.

Structure
REQ-031 Package tdm_pkg SHALL hold the state encoding (HUNT=0, LOCKED=1), default WIDTH/NCH, and a slot-index width function.
REQ-032 Sub-module tdm_slot_counter SHALL implement the wrapping slot counter with load-to-1 and clear inputs.
REQ-033 Per-slot write enables SHALL be decoded from slot; no other sub-modules.

Verification (NCH=4, WIDTH=8)
REQ-034 Scenario: rst, then sof+0x11, 0x22, 0x33, 0x44 back-to-back -> ch_valid 0001,0010,0100,1000; frame_data=0x44332211 with frame_valid in the 4th output cycle; locked=1.
REQ-035 Scenario: 0xAA, 0xBB without sof, then sof+0x01 -> no pulses for the first two, locked rises after the sof sample, ch_valid[0] with ch_data[7:0]=0x01.
REQ-036 Scenario: sof+0x10, 0x20, then sof+0x30 -> sync_err pulse, ch_data[7:0]=0x30, no frame_valid, next sample lands in slot 1.
REQ-037 Scenario: a full frame, then 0x55 without sof at slot 0 -> sync_err, locked=0, 0x55 discarded.
REQ-038 Scenario: frame with in_valid gaps of 0-3 cycles between samples -> outputs identical to REQ-034 apart from timing.
REQ-039 Scenario: rst after 2 samples of a frame, then a clean frame -> all outputs 0 during reset, only the clean frame produces frame_valid.
